// File: rtl/timer_ctrl.sv
// timer_ctrl: push-button sequencer for an MM:SS down-counter (IDLE/LOAD/RUN/PAUSE/ALARM).
// Define TIMER_CTRL_BLINK_EN to make the alarm LED toggle at the tick rate instead of staying lit.
`timescale 1ns/1ps
module timer_ctrl #(
  parameter int unsigned ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       tick,
  input  logic       zero,
  output logic       load,
  output logic       CE,
  output logic       LED,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    ALARM = 3'd4
  } state_t;

  localparam logic [3:0] ALARM_LAST = 4'(ALARM_SECS - 1);

  state_t     state_q, state_d;
  logic [3:0] alarm_cnt;
  logic       start_p, stop_p;

  // Bit 0 is start, bit 1 is stop; both buttons share one synchronizer/edge-detect pipeline.
  logic [1:0] btn_s1, btn_s2, btn_prev, btn_armed, btn_p;
  logic [1:0] settle;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1    <= '0;
      btn_s2    <= '0;
      btn_prev  <= '0;
      btn_armed <= '0;
      btn_p     <= '0;
      settle    <= '0;
    end else begin
      btn_s1    <= {stop, start};
      btn_s2    <= btn_s1;
      btn_prev  <= btn_s2;
      settle    <= {settle[0], 1'b1};
      // A button only arms after it is seen released once the synchronizer holds real samples,
      // so a button held through reset release never produces a pulse.
      btn_armed <= btn_armed | ({2{settle[1]}} & ~btn_s2);
      btn_p     <= btn_s2 & ~btn_prev & btn_armed;
    end
  end

  assign start_p = btn_p[0];
  assign stop_p  = btn_p[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block is given a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    CE      = 1'b0;
    case (state_q)
      IDLE:  if (start_p) state_d = LOAD;
      LOAD: begin
        load    = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        if (zero)        state_d = ALARM;
        else if (stop_p) state_d = PAUSE;
        else             CE      = tick;
      end
      PAUSE: begin
        if (stop_p)       state_d = IDLE;
        else if (start_p) state_d = RUN;
      end
      ALARM: begin
        if (start_p || stop_p)               state_d = IDLE;
        else if (tick && alarm_cnt == ALARM_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Held at zero outside ALARM, which clears it on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 alarm_cnt <= '0;
    else if (state_q != ALARM)  alarm_cnt <= '0;
    else if (tick)              alarm_cnt <= alarm_cnt + 4'd1;
  end

`ifdef TIMER_CTRL_BLINK_EN
  logic blink;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 blink <= 1'b1;
    else if (state_q != ALARM)  blink <= 1'b1;
    else if (tick)              blink <= ~blink;
  end

  assign LED = (state_q == ALARM) && blink;
`else
  assign LED = (state_q == ALARM);
`endif

  assign state = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: stimulus pushes time-stamped expectations into a scoreboard
// queue; a monitor on the falling edge pops and compares them against the DUT outputs.
`timescale 1ns/1ps
module tb_timer_ctrl;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_ALARM = 3'd4;

  logic       clk = 1'b0;
  logic       reset, start, stop, tick, zero;
  logic       load, ce, led;
  logic [2:0] state;

  typedef struct {
    int         cyc;
    string      name;
    logic       ld;
    logic       ce;
    logic       led;
    logic [2:0] st;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  timer_ctrl #(.ALARM_SECS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .stop  (stop),
    .tick  (tick),
    .zero  (zero),
    .load  (load),
    .CE    (ce),
    .LED   (led),
    .state (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc || {load, ce, led, state} !== {e.ld, e.ce, e.led, e.st}) begin
        errors++;
        $display("FAIL %s cyc %0d (due %0d): got load=%b ce=%b led=%b state=%0d, want load=%b ce=%b led=%b state=%0d",
                 e.name, cyc, e.cyc, load, ce, led, state, e.ld, e.ce, e.led, e.st);
      end
    end
  end

  // LED level in ALARM after n ticks have been seen since entry.
  function automatic logic led_exp(input int n);
`ifdef TIMER_CTRL_BLINK_EN
    return (n % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic step(input logic t = 1'b0);
    @(posedge clk);
    #1;
    tick = t;
  endtask

  task automatic ex(input string n, input logic ld, input logic c, input logic l, input logic [2:0] st);
    sb.push_back('{cyc, n, ld, c, l, st});
  endtask

  task automatic hold(input int n, input string nm, input logic [2:0] st);
    repeat (n) begin
      step();
      ex(nm, 1'b0, 1'b0, 1'b0, st);
    end
  endtask

  task automatic go_run(input string nm);
    step(); start = 1'b1; ex(nm, 1'b0, 1'b0, 1'b0, S_IDLE);
    hold(3, nm, S_IDLE);
    step(); ex(nm, 1'b1, 1'b0, 1'b0, S_LOAD);
    step(); start = 1'b0; ex(nm, 1'b0, 1'b0, 1'b0, S_RUN);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0; zero = 1'b0;

    // Reset state
    step();  ex("rst_hold", 0, 0, 0, S_IDLE);
    step(1); ex("rst_tick", 0, 0, 0, S_IDLE);
    step();  reset = 1'b1;
    hold(5, "idle_after_rst", S_IDLE);

    // Start: load pulse three edges after the first sampling edge, then RUN with CE = tick
    step(); start = 1'b1; ex("start_press", 0, 0, 0, S_IDLE);
    hold(3, "sync_delay", S_IDLE);
    step(1); ex("load_pulse", 1, 0, 0, S_LOAD);
    step();  ex("run_entry", 0, 0, 0, S_RUN);
    step(1); ex("run_ce", 0, 1, 0, S_RUN);
    step();  ex("run_no_tick", 0, 0, 0, S_RUN);
    step();  start = 1'b0; ex("run_held_start", 0, 0, 0, S_RUN);
    step(1); ex("run_ce2", 0, 1, 0, S_RUN);

    // Stop -> PAUSE; CE blocked on the stop cycle and across pause ticks; start resumes
    step();  stop = 1'b1; ex("stop_press", 0, 0, 0, S_RUN);
    step();  ex("stop_sync", 0, 0, 0, S_RUN);
    step(1); ex("ce_before_pause", 0, 1, 0, S_RUN);
    step(1); ex("stop_p_blocks_ce", 0, 0, 0, S_RUN);
    step();  ex("pause_entry", 0, 0, 0, S_PAUSE);
    for (int i = 0; i < 3; i++) begin
      step(1); stop = 1'b0; ex("pause_tick", 0, 0, 0, S_PAUSE);
      step();  ex("pause_gap", 0, 0, 0, S_PAUSE);
    end
    step(); start = 1'b1; ex("resume_press", 0, 0, 0, S_PAUSE);
    hold(3, "resume_sync", S_PAUSE);
    step();  ex("resume_no_load", 0, 0, 0, S_RUN);
    step(1); start = 1'b0; ex("resume_ce", 0, 1, 0, S_RUN);

    // PAUSE with start and stop together cancels to IDLE
    step(); stop = 1'b1; ex("stop2_press", 0, 0, 0, S_RUN);
    hold(3, "stop2_sync", S_RUN);
    step(); stop = 1'b0; ex("pause2_entry", 0, 0, 0, S_PAUSE);
    hold(3, "pause2_wait", S_PAUSE);
    step(); start = 1'b1; stop = 1'b1; ex("both_press", 0, 0, 0, S_PAUSE);
    hold(3, "both_sync", S_PAUSE);
    step(); start = 1'b0; stop = 1'b0; ex("both_to_idle", 0, 0, 0, S_IDLE);
    hold(3, "idle_wait", S_IDLE);

    // stop alone is ignored in IDLE
    step(); stop = 1'b1; ex("idle_stop", 0, 0, 0, S_IDLE);
    hold(5, "idle_stop_ignored", S_IDLE);
    step(); stop = 1'b0; ex("idle_stop_rel", 0, 0, 0, S_IDLE);
    hold(2, "idle_wait2", S_IDLE);

    // zero coincident with tick and stop_p in RUN -> ALARM, then IDLE after the 10th tick
    go_run("run3");
    hold(2, "run3_hold", S_RUN);
    step(); stop = 1'b1; ex("stop3_press", 0, 0, 0, S_RUN);
    hold(2, "stop3_sync", S_RUN);
    step(1); zero = 1'b1; ex("zero_tick_stop", 0, 0, 0, S_RUN);
    step();  stop = 1'b0; ex("alarm_entry", 0, 0, led_exp(0), S_ALARM);
    for (int i = 0; i < 10; i++) begin
      step(1); ex("alarm_tick", 0, 0, led_exp(i), S_ALARM);
      step();
      if (i == 9) ex("alarm_done", 0, 0, 0, S_IDLE);
      else        ex("alarm_gap", 0, 0, led_exp(i + 1), S_ALARM);
    end

    // Zero preset: LOAD -> RUN -> ALARM with no CE; a start press aborts the alarm
    hold(2, "idle_zero", S_IDLE);
    step(); start = 1'b1; ex("zstart_press", 0, 0, 0, S_IDLE);
    hold(3, "zstart_sync", S_IDLE);
    step(1); ex("zload", 1, 0, 0, S_LOAD);
    step(1); start = 1'b0; ex("zrun_no_ce", 0, 0, 0, S_RUN);
    step();  ex("zalarm", 0, 0, 1, S_ALARM);
    step();  ex("zalarm_hold", 0, 0, 1, S_ALARM);
    step();  ex("zalarm_hold", 0, 0, 1, S_ALARM);
    step();  start = 1'b1; ex("abort_press", 0, 0, 1, S_ALARM);
    repeat (3) begin
      step(); ex("abort_sync", 0, 0, 1, S_ALARM);
    end
    step(); start = 1'b0; zero = 1'b0; ex("abort_idle", 0, 0, 0, S_IDLE);
    hold(3, "idle_wait3", S_IDLE);

    // Asynchronous reset mid-RUN with start held through release
    step(); start = 1'b1; ex("rst_start_press", 0, 0, 0, S_IDLE);
    hold(3, "rst_start_sync", S_IDLE);
    step();  ex("rst_load", 1, 0, 0, S_LOAD);
    step();  ex("rst_run", 0, 0, 0, S_RUN);
    step(1); ex("run_pre_rst", 0, 1, 0, S_RUN);
    step(1); #2 reset = 1'b0; ex("rst_async", 0, 0, 0, S_IDLE);
    hold(2, "rst_low", S_IDLE);
    step(); reset = 1'b1; ex("rst_release", 0, 0, 0, S_IDLE);
    hold(10, "held_no_pulse", S_IDLE);
    step(); start = 1'b0; ex("held_release", 0, 0, 0, S_IDLE);
    hold(3, "idle_wait4", S_IDLE);
    go_run("repress");
    hold(2, "final_run", S_RUN);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
